// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end: redirect kinds,
// fetch state encoding and the default bubble instruction.
package fetch_pkg;

  localparam logic [1:0] KIND_BRANCH = 2'b00;
  localparam logic [1:0] KIND_JUMP   = 2'b01;
  localparam logic [1:0] KIND_JR     = 2'b10;

  localparam logic [31:0] NOP_INSN_DEFAULT = 32'h0000_0000;

  // HOLD: settle after reset; FETCH: normal request stream;
  // DROP: retire a stale outstanding request after a redirect.
  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    FETCH = 2'b01,
    DROP  = 2'b10
  } state_t;

endpackage

// File: rtl/next_pc_select.sv
// Redirect target selection: branch adder, jump pass-through and jr.
// The reserved kind yields target_valid = 0 so it never redirects.
module next_pc_select
  import fetch_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [31:0] branch_base,
  input  logic [16:0] branch_offset,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic [31:0] target,
  output logic        target_valid
);

  logic [31:0] branch_target;

  // Branch offset is a signed word count; the sum wraps modulo 2^32.
  assign branch_target = branch_base + {{15{branch_offset[16]}}, branch_offset};

  // Select the redirect target for the requested kind.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    target       = '0;
    target_valid = 1'b0;
    case (kind)
      KIND_BRANCH: begin
        target       = branch_target;
        target_valid = 1'b1;
      end
      KIND_JUMP: begin
        target       = jump_target;
        target_valid = 1'b1;
      end
      KIND_JR: begin
        target       = jr_target;
        target_valid = 1'b1;
      end
      default: begin
        target       = '0;
        target_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues word requests to
// instruction memory and presents fetched instructions to decode, handling
// wait states, decode stalls and redirect squashing.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_kind,
  input  logic [31:0] branch_base,
  input  logic [16:0] branch_offset,
  input  logic [31:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        fetch_valid,
  output logic [31:0] fetch_insn,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_pc_plus1
);

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_plus1;
  logic        pending;
  logic [31:0] pending_target;
  logic [31:0] sel_target;
  logic        sel_valid;
  logic        redirect;

  next_pc_select u_next_pc_select (
    .kind          (redirect_kind),
    .branch_base   (branch_base),
    .branch_offset (branch_offset),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .target        (sel_target),
    .target_valid  (sel_valid)
  );

  // A reserved redirect kind is ignored entirely.
  assign redirect  = redirect_valid & sel_valid;
  assign pc_plus1  = pc + 32'd1;
  // The PC only moves when a request retires, so the address is stable
  // across wait states and is the stale address while in DROP.
  assign imem_addr = pc;

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= HOLD;
    else       state <= state_next;
  end

  // Next-state and request decode.
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    case (state)
      HOLD: state_next = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (redirect && !imem_ready) state_next = DROP;
      end
      DROP: begin
        imem_req = 1'b1;
        if (imem_ready) state_next = FETCH;
      end
      default: state_next = HOLD;
    endcase
  end

  // PC, pending redirect and decode-facing outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc             <= RESET_PC;
      pending        <= 1'b0;
      pending_target <= '0;
      fetch_valid    <= 1'b0;
      fetch_insn     <= NOP_INSN;
      fetch_pc       <= '0;
      fetch_pc_plus1 <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            fetch_valid <= 1'b0;
            fetch_insn  <= NOP_INSN;
            if (imem_ready) begin
              pc <= sel_target;
            end else begin
              pending_target <= sel_target;
              pending        <= 1'b1;
            end
          end else if (stall) begin
            // Hold everything; accepted data is dropped and refetched later.
          end else if (imem_ready) begin
            fetch_insn     <= imem_rdata;
            fetch_pc       <= pc;
            fetch_pc_plus1 <= pc_plus1;
            fetch_valid    <= 1'b1;
            pc             <= pc_plus1;
          end else begin
            fetch_valid <= 1'b0;
            fetch_insn  <= NOP_INSN;
          end
        end
        DROP: begin
          fetch_valid <= 1'b0;
          fetch_insn  <= NOP_INSN;
          if (imem_ready) begin
            // Latest redirect wins, including one arriving on the retire edge.
            if (redirect)     pc <= sel_target;
            else if (pending) pc <= pending_target;
            pending <= 1'b0;
          end else if (redirect) begin
            pending_target <= sel_target;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
